// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the multicycle restoring divider:
//   - div_state_e : FSM state encoding (IDLE / RUN / DONE)
//   - DIV_WIDTH   : default operand width
//   - DIV_CNT_W   : iteration counter width for the default operand width
// -----------------------------------------------------------------------------
package divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage : divider_pkg

// File: rtl/div_restoring_step.sv
// -----------------------------------------------------------------------------
// div_restoring_step
// One combinational iteration of restoring division on unsigned magnitudes.
// Ports:
//   rem_in   [WIDTH-1:0]  partial remainder before this iteration
//   bit_in                next dividend bit shifted into the remainder
//   dvs      [WIDTH-1:0]  divisor magnitude
//   rem_out  [WIDTH-1:0]  partial remainder after this iteration
//   q_bit                 quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_restoring_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;
    logic [WIDTH:0] result_s;
    logic           fits_s;
    logic           unused_msb_s;

    // Shift-subtract-restore: keep the trial difference only when it does not borrow.
    always_comb begin
        shifted_s = {rem_in, bit_in};
        fits_s    = (shifted_s >= {1'b0, dvs});
        trial_s   = shifted_s - {1'b0, dvs};
        if (fits_s) begin
            result_s = trial_s;
        end else begin
            result_s = shifted_s;
        end
        // The incoming remainder is always below the divisor, so the result
        // is below the divisor too and its top bit is always zero.
        rem_out = result_s[WIDTH-1:0];
        q_bit   = fits_s;
    end

    assign unused_msb_s = result_s[WIDTH];

endmodule : div_restoring_step

// File: rtl/divider_unit.sv
// -----------------------------------------------------------------------------
// divider_unit
// Multicycle restoring divider (DIV / DIVU), one quotient bit per clock.
// Optional build macro: DIVIDER_EARLY_OUT_EN -- finish in one cycle when
// |dividend| < |divisor| (including a zero dividend).
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 request, accepted only in IDLE
//   is_signed             1 = two's-complement DIV, 0 = DIVU (sampled with start)
//   dividend, divisor     operands [WIDTH-1:0] (sampled with start)
//   busy                  high while iterating (RUN)
//   done                  one-cycle completion pulse
//   quotient, remainder   results [WIDTH-1:0], held until the next completion
//   div_by_zero           divisor was zero, held with the results
// -----------------------------------------------------------------------------
module divider_unit
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude, becomes the raw quotient
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] mag_dvd_s;
    logic [WIDTH-1:0] mag_dvs_s;
    logic [WIDTH-1:0] step_rem_s;
    logic             step_qbit_s;
    logic [WIDTH-1:0] final_q_s;

    div_restoring_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .dvs     (dvs_q),
        .rem_out (step_rem_s),
        .q_bit   (step_qbit_s)
    );

    // Operand magnitudes; |MIN_INT| wraps to itself, which is correct as unsigned.
    always_comb begin
        if (is_signed && dividend[WIDTH-1]) begin
            mag_dvd_s = -dividend;
        end else begin
            mag_dvd_s = dividend;
        end
        if (is_signed && divisor[WIDTH-1]) begin
            mag_dvs_s = -divisor;
        end else begin
            mag_dvs_s = divisor;
        end
    end

    // Next-state, datapath and result fix-up logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        final_q_s   = {dvd_q[WIDTH-2:0], step_qbit_s};

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = mag_dvd_s;
                    dvs_d   = mag_dvs_s;
                    q_neg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_d = is_signed & dividend[WIDTH-1];
                    rem_d   = {WIDTH{1'b0}};
                    cnt_d   = CNT_W'(WIDTH);
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_d     = DONE;
                        quotient_d  = {WIDTH{1'b1}};
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end
`ifdef DIVIDER_EARLY_OUT_EN
                    else if (mag_dvd_s < mag_dvs_s) begin
                        // Quotient is zero and the dividend is already the remainder.
                        state_d     = DONE;
                        quotient_d  = {WIDTH{1'b0}};
                        remainder_d = dividend;
                        dbz_d       = 1'b0;
                    end
`endif
                    else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = step_rem_s;
                dvd_d = final_q_s;
                cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    // Last iteration: register the sign-corrected results so
                    // they are valid during the done cycle.
                    state_d     = DONE;
                    quotient_d  = q_neg_q ? -final_q_s : final_q_s;
                    remainder_d = r_neg_q ? -step_rem_s : step_rem_s;
                    dbz_d       = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            rem_q       <= {WIDTH{1'b0}};
            dvd_q       <= {WIDTH{1'b0}};
            dvs_q       <= {WIDTH{1'b0}};
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule : divider_unit

// File: tb/tb_divider_unit.sv
// -----------------------------------------------------------------------------
// tb_divider_unit
// Directed self-checking bench for divider_unit (WIDTH = 32).
// Honours DIVIDER_EARLY_OUT_EN for the expected latency of early-out vectors.
// -----------------------------------------------------------------------------
module tb_divider_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    logic [31:0] last_q = 32'd0;
    logic [31:0] last_r = 32'd0;

    divider_unit #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef DIVIDER_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } vec_t;

    // Launch one operation and observe it. Optional second start pulse at
    // cycle glitch_cyc (0 = none). Returns cycles to done, busy cycles and
    // whether results stayed held while busy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input int glitch_cyc,
                          output int lat, output int busy_cnt, output logic held_ok);
        lat      = -1;
        busy_cnt = 0;
        held_ok  = 1'b1;
        @(negedge clock);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0000_0003;
        is_signed = ~s;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            if (k == glitch_cyc) begin
                dividend = 32'd9;
                divisor  = 32'd3;
                start    = 1'b1;
            end else begin
                start    = 1'b0;
            end
            if (busy) begin
                busy_cnt++;
                if (quotient !== last_q || remainder !== last_r) held_ok = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        is_signed = 1'b0;
        dividend = 32'd0;
        divisor = 32'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b dbz=%b q=%h r=%h want all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
    endtask

    task automatic test_vectors();
        vec_t v[10];
        int   lat, bc;
        logic held;
        v[0] = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 33};
        v[1] = '{32'hFFFFFFF9,  32'd2,         1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 33};
        v[2] = '{32'hFFFFFFF9,  32'd2,         1'b0, 32'h7FFFFFFC,  32'd1,         1'b0, 33};
        v[3] = '{32'hFFFFFFFF,  32'd1,         1'b0, 32'hFFFFFFFF,  32'd0,         1'b0, 33};
        v[4] = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 32'h80000000,  32'd0,         1'b0, 33};
        v[5] = '{32'h00001234,  32'd0,         1'b0, 32'hFFFFFFFF,  32'h00001234,  1'b1, 1};
        v[6] = '{32'd7,         32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD,  32'd1,         1'b0, 33};
        v[7] = '{32'd5,         32'd9,         1'b0, 32'd0,         32'd5,         1'b0, EARLY_LAT};
        v[8] = '{32'hFFFFFFFB,  32'd9,         1'b1, 32'd0,         32'hFFFFFFFB,  1'b0, EARLY_LAT};
        v[9] = '{32'hFFFFFF00,  32'd0,         1'b1, 32'hFFFFFFFF,  32'hFFFFFF00,  1'b1, 1};
        for (int i = 0; i < 10; i++) begin
            run_op(v[i].a, v[i].b, v[i].s, 0, lat, bc, held);
            checks++;
            if (lat !== v[i].lat) begin
                failures++;
                $display("FAIL vec%0d_latency got %0d want %0d", i, lat, v[i].lat);
            end
            checks++;
            if (bc !== v[i].lat - 1) begin
                failures++;
                $display("FAIL vec%0d_busy_cycles got %0d want %0d", i, bc, v[i].lat - 1);
            end
            checks++;
            if (quotient !== v[i].q || remainder !== v[i].r || div_by_zero !== v[i].z) begin
                failures++;
                $display("FAIL vec%0d_result got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                         i, quotient, remainder, div_by_zero, v[i].q, v[i].r, v[i].z);
            end
            checks++;
            if (held !== 1'b1) begin
                failures++;
                $display("FAIL vec%0d_hold results changed while busy (want %h/%h)", i, last_q, last_r);
            end
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL vec%0d_done_pulse got done=%b busy=%b want 0/0", i, done, busy);
            end
            last_q = v[i].q;
            last_r = v[i].r;
        end
    endtask

    task automatic test_ignore_start();
        int   lat, bc;
        logic held;
        run_op(32'd100, 32'd7, 1'b0, 10, lat, bc, held);
        checks++;
        if (lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
            failures++;
            $display("FAIL ignore_start got lat=%0d q=%0d r=%0d want 33/14/2", lat, quotient, remainder);
        end
        last_q = 32'd14;
        last_r = 32'd2;
        // Now in the done cycle: a start here must be ignored.
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd14) begin
            failures++;
            $display("FAIL start_in_done got busy=%b done=%b q=%0d want 0/0/14", busy, done, quotient);
        end
    endtask

    task automatic test_reset_midflight();
        int seen_done = 0;
        @(negedge clock);
        dividend  = 32'd100;
        divisor   = 32'd7;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
            failures++;
            $display("FAIL midflight_reset got busy=%b done=%b dbz=%b q=%h r=%h want all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            failures++;
            $display("FAIL midflight_no_done got %0d active cycles want 0", seen_done);
        end
        last_q = 32'd0;
        last_r = 32'd0;
        // A fresh operation after reset still works.
        begin
            int   lat, bc;
            logic held;
            run_op(32'd100, 32'd7, 1'b0, 0, lat, bc, held);
            checks++;
            if (lat !== 33 || quotient !== 32'd14 || remainder !== 32'd2) begin
                failures++;
                $display("FAIL after_reset got lat=%0d q=%0d r=%0d want 33/14/2", lat, quotient, remainder);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_divider_unit

// File: doc/divider_unit.md
Name: divider_unit

Overview:
- Multicycle restoring divider for the MIPS datapath; the iterative, subtractive counterpart of the single-step Adder.
- Executes DIV/DIVU: one quotient bit per clock, quotient to LO, remainder to HI.
- Controlled by the multicycle control FSM through a start/busy/done handshake.
- Sits beside the ALU; the HI/LO registers capture its outputs on done.

Parameters:
- WIDTH, 32, operand/result width in bits (≥ 2).

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  high while an operation is in flight (RUN state).
- done  output  1  single-cycle completion pulse.
- quotient  output  WIDTH  result for LO; held until next accepted start.
- remainder  output  WIDTH  result for HI; held until next accepted start.
- div_by_zero  output  1  set with done when divisor was 0; held with results.

Behaviour:
- Reset value (applied on any clock edge with reset=1, including mid-operation):
  - state = IDLE.
  - busy, done, div_by_zero, quotient and remainder = 0.
  - Any in-flight operation is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches the operands and is_signed.
  - Magnitudes are formed: |x| when signed, otherwise raw.
  - Result sign flags are recorded: q_neg = sign(dividend) XOR sign(divisor); r_neg = sign(dividend).
  - If divisor = 0: go to DONE directly.
  - Otherwise: clear the partial remainder, set the bit counter to WIDTH, go to RUN.
- RUN, once per cycle:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - trial = partial remainder − divisor magnitude, computed at WIDTH+1 bits.
  - If trial is non-negative: the partial remainder takes trial and the shifted-in quotient bit is 1; otherwise the quotient bit is 0.
  - Counter decrements; after WIDTH iterations go to DONE.
- DONE, for exactly one cycle:
  - done = 1.
  - quotient = q_neg ? −q : q; remainder = r_neg ? −r : r.
  - Next state is IDLE.
  - start asserted in DONE is ignored.
- Latency: start accepted at edge N.
  - Normal operation: busy is high for cycles N+1 .. N+WIDTH; done is high in cycle N+WIDTH+1, i.e. 33 cycles for WIDTH=32.
  - Divide by zero: done is high in cycle N+1 and busy never rises.
- Busy/start rules:
  - start while busy is ignored; the operands are not resampled.
  - Operand inputs are don't-care after the start edge.
- Divide by zero: quotient = all-ones, remainder = dividend (unmodified), div_by_zero = 1.
- Signed semantics:
  - Truncation toward zero; the remainder takes the sign of the dividend.
  - Overflow case MIN_INT / −1 gives quotient = MIN_INT, remainder = 0, with no flag.
- Arithmetic: magnitudes are unsigned WIDTH bits (|MIN_INT| = 2^(WIDTH−1) fits); the subtractor is WIDTH+1 bits.
- quotient, remainder and div_by_zero are registered and change only in DONE or on reset.

Optional Feature:
- Macro: DIVIDER_EARLY_OUT_EN.
- Defined:
  - In IDLE, if |dividend| < |divisor| (divisor ≠ 0), go straight to DONE.
  - Result: quotient = 0, remainder = dividend; done is in cycle N+1.
  - Also if dividend = 0: quotient = 0, remainder = 0, done in cycle N+1.
- Undefined: these cases run the full WIDTH iterations; results are bit-identical.

Decomposition:
- Package divider_pkg holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - DIV_WIDTH default 32.
  - DIV_CNT_W = $clog2(WIDTH+1).
- One natural sub-module, div_restoring_step: combinational single iteration.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
- The FSM, sign fix-up and counter stay in divider_unit.

Test Plan:
- Unsigned: start with dividend=100, divisor=7, is_signed=0 -> done at cycle N+33, quotient=14, remainder=2, div_by_zero=0; busy high for 32 cycles.
- Signed: dividend=0xFFFFFFF9 (−7), divisor=2 -> quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1). Same operands unsigned -> quotient=0x7FFFFFFC, remainder=1.
- Corner cases:
  - Unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
  - Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
- Divide by zero: dividend=0x1234, divisor=0 -> done at N+1, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Handshake/reset:
  - Start 100/7; pulse start with 9/3 at cycle N+10 -> ignored, result still 14/2.
  - Restart and assert reset at N+5 -> busy=0, done=0, outputs 0 next edge; no done pulse follows.
- With DIVIDER_EARLY_OUT_EN: 5/9 unsigned -> done at N+1, quotient=0, remainder=5. Without the macro -> same values at N+33.
